// File: rtl/mm_sched_pkg.sv
// rtl/mm_sched_pkg.sv - shared types, default sizing and PE index helper for the k-stage scheduler
package mm_sched_pkg;

    localparam int DEF_ROW1        = 2;
    localparam int DEF_COL1        = 3;
    localparam int DEF_COL2        = 5;
    localparam int DEF_DRAIN_CYC   = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_NPE         = DEF_ROW1 * DEF_COL2 * DEF_COL1;
    localparam int DEF_STAGE_W     = $clog2(DEF_COL1) + 1;
    localparam int WDOG_W          = $clog2(DEF_TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE,
        ERR
    } sched_state_e;

    function automatic int pe_idx(input int i, input int j, input int k);
        return ((i * DEF_COL2) + j) * DEF_COL1 + k;
    endfunction

endpackage

// File: rtl/mm_stage_scheduler_if.sv
// rtl/mm_stage_scheduler_if.sv - scheduler control bundle; SCHED_PERF_CNT_EN adds the perf counters
interface mm_stage_scheduler_if
    import mm_sched_pkg::*;
#(
    parameter int NPE     = DEF_NPE,
    parameter int STAGE_W = DEF_STAGE_W
);
    logic               Start;
    logic [NPE-1:0]     pe_done;
    logic [NPE-1:0]     pe_en;
    logic               acc_clr;
    logic [STAGE_W-1:0] stage;
    logic               busy;
    logic               done;
    logic               err;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]        cyc_cnt;
    logic [31:0]        stall_cnt;

    modport master (output Start, pe_done,
                    input  pe_en, acc_clr, stage, busy, done, err, cyc_cnt, stall_cnt);
    modport slave  (input  Start, pe_done,
                    output pe_en, acc_clr, stage, busy, done, err, cyc_cnt, stall_cnt);
`else
    modport master (output Start, pe_done,
                    input  pe_en, acc_clr, stage, busy, done, err);
    modport slave  (input  Start, pe_done,
                    output pe_en, acc_clr, stage, busy, done, err);
`endif
endinterface

// File: rtl/mm_stage_done_reduce.sv
// rtl/mm_stage_done_reduce.sv - ANDs the pe_done bits belonging to the current k-stage
module mm_stage_done_reduce #(
    parameter int NPE     = 30,
    parameter int COL1    = 3,
    parameter int STAGE_W = 3
) (
    input  logic [NPE-1:0]     i_pe_done,
    input  logic [STAGE_W-1:0] i_stage,
    output logic               o_stage_done
);

    always_comb begin
        o_stage_done = 1'b1;
        for (int n = 0; n < NPE; n++) begin
            if (((n % COL1) == int'(i_stage)) && !i_pe_done[n]) begin
                o_stage_done = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mm_stage_scheduler.sv
// rtl/mm_stage_scheduler.sv - k-stage accumulation sequencer for the PE array; SCHED_PERF_CNT_EN adds cycle/stall counters
module mm_stage_scheduler
    import mm_sched_pkg::*;
#(
    parameter int ROW1        = DEF_ROW1,
    parameter int COL1        = DEF_COL1,
    parameter int COL2        = DEF_COL2,
    parameter int DRAIN_CYC   = DEF_DRAIN_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    mm_stage_scheduler_if.slave  bus
);

    localparam int NPE     = ROW1 * COL2 * COL1;
    localparam int STAGE_W = $clog2(COL1) + 1;
    localparam int WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam int DR_W    = $clog2(DRAIN_CYC + 1);

    sched_state_e       r_state;
    logic [NPE-1:0]     r_pe_en;
    logic               r_acc_clr;
    logic [STAGE_W-1:0] r_stage;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [WD_W-1:0]    r_wdog;
    logic [DR_W-1:0]    r_drain;
    logic               w_stage_done;
    logic               w_last;

    function automatic logic [NPE-1:0] f_mask(input logic [STAGE_W-1:0] s);
        logic [NPE-1:0] m;
        m = '0;
        for (int n = 0; n < NPE; n++) begin
            m[n] = ((n % COL1) == int'(s));
        end
        return m;
    endfunction

    mm_stage_done_reduce #(
        .NPE     (NPE),
        .COL1    (COL1),
        .STAGE_W (STAGE_W)
    ) u_reduce (
        .i_pe_done    (bus.pe_done),
        .i_stage      (r_stage),
        .o_stage_done (w_stage_done)
    );

    assign w_last = (r_stage == STAGE_W'(COL1 - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pe_en   <= '0;
            r_acc_clr <= 1'b0;
            r_stage   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_wdog    <= '0;
            r_drain   <= '0;
        end else begin
            r_acc_clr <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.Start) begin
                        r_state   <= CLEAR;
                        r_acc_clr <= 1'b1;
                        r_busy    <= 1'b1;
                        r_err     <= 1'b0;
                        r_stage   <= '0;
                    end
                end
                CLEAR: begin
                    r_state <= RUN;
                    r_pe_en <= f_mask('0);
                    r_wdog  <= '0;
                end
                RUN: begin
                    // A completed stage always wins over the watchdog in the same cycle
                    if (w_stage_done) begin
                        r_wdog <= '0;
                        if (w_last) begin
                            r_state <= DRAIN;
                            r_pe_en <= '0;
                            r_drain <= '0;
                        end else begin
                            r_stage <= r_stage + 1'b1;
                            r_pe_en <= f_mask(r_stage + 1'b1);
                        end
                    end else if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
                        r_state <= ERR;
                        r_pe_en <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain == DR_W'(DRAIN_CYC - 1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                DONE, ERR: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_pe_en <= '0;
                end
            endcase
        end
    end

    assign bus.pe_en   = r_pe_en;
    assign bus.acc_clr = r_acc_clr;
    assign bus.stage   = r_stage;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] r_cyc_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (bus.Start) begin
                r_cyc_cnt   <= '0;
                r_stall_cnt <= '0;
            end
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if ((r_state == RUN) && !w_stage_done) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign bus.cyc_cnt   = r_cyc_cnt;
    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mm_stage_scheduler.sv
// tb/tb_mm_stage_scheduler.sv - randomized scoreboard bench for mm_stage_scheduler
`timescale 1ns/1ps
module tb_mm_stage_scheduler;
    import mm_sched_pkg::*;

    localparam int NPE  = DEF_NPE;
    localparam int COL1 = DEF_COL1;
    localparam int COL2 = DEF_COL2;
    localparam int ROW1 = DEF_ROW1;
    localparam int STW  = DEF_STAGE_W;
    localparam int DRN  = DEF_DRAIN_CYC;
    localparam int TMO  = DEF_TIMEOUT_CYC;
    localparam int BIG  = 32'h3fff_ffff;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mm_stage_scheduler_if #(.NPE(NPE), .STAGE_W(STW)) bus ();

    mm_stage_scheduler #(
        .ROW1        (ROW1),
        .COL1        (COL1),
        .COL2        (COL2),
        .DRAIN_CYC   (DRN),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int c; int stg; } run_t;
    typedef struct { bit is_err; int c; int stall; int cycs; } ev_t;

    int   clr_q[$];
    run_t run_q[$];
    ev_t  ev_q[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [NPE-1:0] exp_mask(input int s);
        logic [NPE-1:0] m;
        for (int n = 0; n < NPE; n++) m[n] = ((n % COL1) == s);
        return m;
    endfunction

    // Per-transaction schedule: stage k is current during [e_a[k], en_a[k]], complete from rel_a[k]
    int e_a[COL1];
    int en_a[COL1];
    int rel_a[COL1];
    int blk_a[COL1];
    bit act = 1'b0;

    function automatic logic [NPE-1:0] gen(input int c);
        logic [NPE-1:0] v;
        for (int n = 0; n < NPE; n++) begin
            int k;
            k = n % COL1;
            if (act && c >= e_a[k] && c <= en_a[k])
                v[n] = (c >= rel_a[k]) ? 1'b1 : ((n == blk_a[k]) ? 1'b0 : 1'($urandom_range(0, 1)));
            else
                v[n] = 1'($urandom_range(0, 1));
        end
        return v;
    endfunction

    bit   mon_on = 1'b0;
    logic prev_err = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.acc_clr === 1'b1) begin
                if (clr_q.size() == 0) chk("acc_clr_unexpected", 1, 0);
                else begin
                    int c;
                    c = clr_q.pop_front();
                    chk("acc_clr_cycle", cyc, c);
                    chk("busy_clear", bus.busy, 1);
                end
            end
            if (bus.pe_en !== '0) begin
                if (run_q.size() == 0) chk("pe_en_unexpected", bus.pe_en, 0);
                else begin
                    run_t r;
                    r = run_q.pop_front();
                    chk("run_cycle", cyc, r.c);
                    chk("pe_en_mask", bus.pe_en, exp_mask(r.stg));
                    chk("stage", bus.stage, r.stg);
                end
            end
            if (bus.done === 1'b1 || (bus.err === 1'b1 && prev_err !== 1'b1)) begin
                if (ev_q.size() == 0) chk("event_unexpected", {bus.done, bus.err}, 0);
                else begin
                    ev_t e;
                    bit  got_err;
                    e = ev_q.pop_front();
                    got_err = (bus.done !== 1'b1);
                    chk("event_is_err", got_err, e.is_err);
                    chk("event_cycle", cyc, e.c);
                    chk("busy_event", bus.busy, 1);
                    chk("pe_en_event", bus.pe_en, 0);
`ifdef SCHED_PERF_CNT_EN
                    if (!e.is_err) begin
                        chk("stall_cnt", bus.stall_cnt, e.stall);
                        chk("cyc_cnt", bus.cyc_cnt, e.cycs);
                    end
`endif
                end
            end
            prev_err = bus.err;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pe_en"}, bus.pe_en, 0);
        chk({tag, "_acc_clr"}, bus.acc_clr, 0);
        chk({tag, "_stage"}, bus.stage, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    // d*: incomplete cycles per stage; to_stg: stage that never completes (-1 none);
    // rst_off: cycles after stage-2 entry at which rst is asserted (-1 none)
    task automatic txn(input int d0, input int d1, input int d2, input int to_stg,
                       input int blk0, input bit noise, input int rst_off);
        int d[COL1];
        int t0, t_last, sum_d, nxt, rst_cyc, last;
        bit stop;
        ev_t ev;
        d[0] = d0; d[1] = d1; d[2] = d2;
        @(negedge clk);
        t0 = cyc;
        for (int s = 0; s < COL1; s++)
            blk_a[s] = pe_idx($urandom_range(0, ROW1 - 1), $urandom_range(0, COL2 - 1), s);
        if (blk0 >= 0) blk_a[0] = blk0;
        nxt = t0 + 2; sum_d = 0; stop = 1'b0;
        for (int s = 0; s < COL1; s++) begin
            if (stop) begin
                e_a[s] = BIG; en_a[s] = -1; rel_a[s] = BIG;
            end else begin
                e_a[s] = nxt;
                if (s == to_stg) begin
                    en_a[s] = nxt + TMO - 1; rel_a[s] = BIG; stop = 1'b1;
                end else begin
                    en_a[s] = nxt + d[s]; rel_a[s] = nxt + d[s]; sum_d += d[s];
                end
                nxt = en_a[s] + 1;
            end
        end
        t_last  = (to_stg >= 0) ? nxt : nxt + DRN;
        rst_cyc = (rst_off >= 0) ? e_a[COL1 - 1] + rst_off : BIG;
        if (t0 + 1 <= rst_cyc) clr_q.push_back(t0 + 1);
        for (int s = 0; s < COL1; s++)
            for (int c = e_a[s]; c <= en_a[s]; c++)
                if (c <= rst_cyc) run_q.push_back('{c: c, stg: s});
        if (t_last <= rst_cyc) begin
            ev.is_err = (to_stg >= 0); ev.c = t_last; ev.stall = sum_d; ev.cycs = t_last - t0 - 1;
            ev_q.push_back(ev);
        end
        act = 1'b1;
        bus.Start = 1'b1;
        bus.pe_done = gen(t0);
        last = (rst_cyc < t_last) ? rst_cyc : t_last;
        while (cyc < last) begin
            @(negedge clk);
            bus.Start = noise && ($urandom_range(0, 3) == 0);
            bus.pe_done = gen(cyc);
            if (cyc == rst_cyc) rst = 1'b1;
        end
        @(negedge clk);
        act = 1'b0;
        bus.Start = 1'b0;
        bus.pe_done = gen(cyc);
        if (rst_cyc < t_last) begin
            rst = 1'b0;
            chk_all_zero("mid_rst");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout at cycle %0d: got running expected finished", cyc);
        $fatal(1);
    end

    initial begin
        bus.Start = 1'b0;
        bus.pe_done = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);

        txn(0, 0, 0, -1, -1, 1'b0, -1);
        txn(0, 19, 0, -1, -1, 1'b0, -1);
        txn(0, 0, 0, 0, pe_idx(1, 4, 0), 1'b0, -1);
        chk("err_sticky", bus.err, 1);
        chk("busy_after_err", bus.busy, 0);
        txn(1, 2, 3, -1, -1, 1'b0, -1);
        chk("err_cleared", bus.err, 0);
        txn(0, 0, 10, -1, -1, 1'b1, 3);

        @(negedge clk);
        bus.Start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        rst = 1'b0;
        chk("start_rst_busy", bus.busy, 0);
        @(negedge clk);
        chk("start_rst_idle", bus.busy, 0);

        for (int t = 0; t < 20; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            txn($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), -1, -1, 1'b1, -1);
        end
        txn($urandom_range(0, 3), $urandom_range(0, 3), 0, 2, -1, 1'b1, -1);
        txn($urandom_range(0, 3), 0, $urandom_range(0, 3), -1, -1, 1'b1, -1);

        repeat (5) @(negedge clk);
        chk("clr_q_empty", clr_q.size(), 0);
        chk("run_q_empty", run_q.size(), 0);
        chk("ev_q_empty", ev_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
